// File: rtl/width_packer_if.sv
// width_packer_if: narrow input stream plus wide output stream of the width packer.
// The packer connects through the slave modport; the source/sink pair uses master.
interface width_packer_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4
);
    localparam int unsigned OUT_W = IN_W * RATIO;
    localparam int unsigned CNT_W = $clog2(RATIO + 1);

    logic [IN_W-1:0]  bits;
    logic             i_valid_input;
    logic             i_last;
    logic             ready;
    logic             i_ready_output;
    logic [OUT_W-1:0] data;
    logic             o_valid_output;
    logic [CNT_W-1:0] o_count;
    logic             o_last;

    modport master (
        output bits,
        output i_valid_input,
        output i_last,
        output i_ready_output,
        input  ready,
        input  data,
        input  o_valid_output,
        input  o_count,
        input  o_last
    );

    modport slave (
        input  bits,
        input  i_valid_input,
        input  i_last,
        input  i_ready_output,
        output ready,
        output data,
        output o_valid_output,
        output o_count,
        output o_last
    );
endinterface

// File: rtl/width_packer.sv
// width_packer: collects RATIO narrow words into one wide word with backpressure on both
// sides, end-of-burst flush on i_last and an optional idle-timeout flush (TIMEOUT != 0).
// Define WIDTH_PACKER_MSB_FIRST_EN to place the first word in the MSB lane instead of the LSB.
module width_packer #(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned RATIO   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input logic           clk,
    input logic           reset,
    width_packer_if.slave bus
);
    localparam int unsigned OUT_W  = IN_W * RATIO;
    localparam int unsigned CNT_W  = $clog2(RATIO + 1);
    localparam int unsigned IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RATIO - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StFill, StFlush} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OUT_W-1:0]  acc_q;
    logic [OUT_W-1:0]  acc_d;
    logic [IDLE_W-1:0] idle_q;
    logic [OUT_W-1:0]  data_q;
    logic              valid_q;
    logic [CNT_W-1:0]  count_q;
    logic              last_q;

    logic              out_free;
    logic              in_fire;
    logic              emit;
    int unsigned       lane_sel;

    // Output register can take a new word when empty or being drained this cycle.
    assign out_free  = !valid_q || bus.i_ready_output;
    assign bus.ready = !reset && out_free && (state_q != StFlush);
    assign in_fire   = bus.i_valid_input && bus.ready;
    assign emit      = in_fire && ((cnt_q == CNT_LAST) || bus.i_last);

`ifdef WIDTH_PACKER_MSB_FIRST_EN
    assign lane_sel = RATIO - 1 - 32'(cnt_q);
`else
    assign lane_sel = 32'(cnt_q);
`endif

    // Unfilled lanes of acc_q are always zero, so OR-ing merges the new lane in place.
    assign acc_d = acc_q | (OUT_W'(bus.bits) << (lane_sel * IN_W));

    assign bus.data           = data_q;
    assign bus.o_valid_output = valid_q;
    assign bus.o_count        = count_q;
    assign bus.o_last         = last_q;

    // FSM, accumulator, idle counter and output register in one sequential process.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            // Drain on handshake; a reload below overrides this in the same cycle.
            if (bus.i_ready_output) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                StIdle, StFill: begin
                    if (in_fire) begin
                        idle_q <= '0;
                        if (emit) begin
                            data_q  <= acc_d;
                            count_q <= cnt_q + CNT_W'(1);
                            last_q  <= bus.i_last;
                            valid_q <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            acc_q   <= acc_d;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= StFill;
                        end
                    end else if ((TIMEOUT != 0) && (state_q == StFill)) begin
                        idle_q <= idle_q + IDLE_W'(1);
                        if (idle_q == IDLE_LAST) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        data_q  <= acc_q;
                        count_q <= cnt_q;
                        last_q  <= 1'b1;
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        idle_q  <= '0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: doc/width_packer.md
# width_packer

Parametrised input-to-output width packer that collects RATIO narrow words into one wide word, with backpressure on both sides, explicit end-of-burst flush and an optional idle-timeout flush. It is the next generation of the 8-to-32 bit packer in `top`. It sits between the bit-stream source and the 32-bit (or wider) framing logic.

## Interface
- `IN_W`, 8, input word width in bits.
- `RATIO`, 4, input words per output word (≥2); `OUT_W = IN_W*RATIO`.
- `TIMEOUT`, 0, idle cycles before a partial word is auto-flushed; 0 disables the timeout.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `bits` in IN_W: input word.
- `i_valid_input` in 1: `bits` is valid.
- `i_last` in 1: the current input word ends a burst; qualified by `i_valid_input`.
- `ready` out 1: the block accepts an input word this cycle.
- `i_ready_output` in 1: downstream accepts the output word.
- `data` out OUT_W: packed output word.
- `o_valid_output` out 1: `data` is valid.
- `o_count` out $clog2(RATIO+1): number of valid lanes in `data` (1..RATIO).
- `o_last` out 1: the output word ends a burst.

## Operation
- **Input accept:** an input word is accepted when `i_valid_input && ready`.
- **Ready rule:** `ready = !reset && (!o_valid_output || i_ready_output)`. This path is combinational from `i_ready_output`.
- **Accumulator:** `acc[OUT_W]` plus lane counter `cnt` (0..RATIO-1).
  - An accepted word is written to lane `cnt`, occupying bits `[cnt*IN_W +: IN_W]`.
  - After the write, `cnt` increments.
- **Emit:** an accepted word emits an output word when `cnt==RATIO-1` or `i_last==1`. On emit:
  - the output register loads `acc` with the new lane merged in;
  - unfilled lanes are zero;
  - `o_count = cnt+1` and `o_last = i_last`;
  - `cnt` and `acc` clear.
- **Output register:** holds `data`, `o_count` and `o_last` stable while `o_valid_output && !i_ready_output`. It clears `o_valid_output` on handshake unless it is reloaded in the same cycle.
- **States:**
  - IDLE (`cnt==0`): valid → FILL; valid with emit → IDLE.
  - FILL (`cnt>0`): emit → IDLE.
  - FILL with timeout expired → FLUSH.
  - FLUSH: `ready` is forced 0. It emits `acc` with `o_count=cnt`, `o_last=1` as soon as the output register is free, then returns to IDLE.
- **Idle counter:** counts cycles in FILL with no accepted input and resets on every accepted word. FLUSH is entered when the count equals `TIMEOUT`.
- Input words are never dropped and never duplicated.

## Timing
- **Reset values:**
  - `data=0`, `o_valid_output=0`, `o_count=0`, `o_last=0`, `ready=0` while `reset` is high.
  - `cnt=0`, idle counter 0, state IDLE.
- **Reset mid-word:** discards the partial accumulator and any pending output word.
- **Latency:** a word that triggers an emit on edge N gives `o_valid_output=1` immediately after edge N.
- **Throughput:** one input word per cycle while the downstream holds `i_ready_output=1`. A full output word appears every RATIO cycles.
- **Simultaneous output handshake and emit:** the register reloads, `o_valid_output` stays 1 and there is no bubble.
- **Output held and `i_ready_output=0`:** `ready=0`. Upstream stalls, including for non-emitting words.
- **`i_last` on the RATIO-th word:** produces a single emit with `o_count=RATIO`, `o_last=1`.
- **`i_last` while `cnt==0`:** emits a one-lane word with `o_count=1`.
- **Timeout flush:** occurs TIMEOUT+1 cycles after the last accepted word if the output register is free; otherwise it waits until the register is free.

## Configuration
- Macro: `WIDTH_PACKER_MSB_FIRST_EN`.
- **Undefined:** the first word lands in the LSB lane, bits `[IN_W-1:0]`.
- **Defined:** the first word lands in the MSB lane, bits `[OUT_W-1 -: IN_W]`.
  - Partial words stay left-aligned with zero LSB lanes.
  - `o_count` is unchanged.

## Test plan
- Reset 3 cycles, then `bits` = 0x11,0x22,0x33,0x44 back-to-back with `i_ready_output=1` → one output: `data=0x44332211`, `o_count=4`, `o_last=0`, the cycle after 0x44 is accepted.
- Same stimulus with `WIDTH_PACKER_MSB_FIRST_EN` defined → `data=0x11223344`.
- 0xAA, 0xBB with `i_last` on 0xBB → `data=0x0000BBAA`, `o_count=2`, `o_last=1`.
- Downstream holds `i_ready_output=0` for 5 cycles while 8 words are offered →
  - `ready` drops after the first emit;
  - `data` stays stable;
  - after release, both words 0x44332211 and 0x88776655 appear in order with no loss.
- `TIMEOUT=4`: send 0x5A then idle → emit `data=0x0000005A`, `o_count=1`, `o_last=1` 5 cycles later.
- Assert `reset` after 2 of 4 words, then send 0x01..0x04 → `data=0x04030201`; no stale lanes.
